// File: rtl/wb_master_bridge.sv
// Wishbone classic initiator for the picorv32 native memory interface.
// It runs one single read/write cycle per request, with error/timeout abort and a sticky error log.
module wb_master_bridge #(
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        err_clr_i,
  output logic        bus_err_o,
  output logic [31:0] err_addr_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_n;
  logic [7:0] cnt;
  logic       timeout_hit;
  logic       fail;
  logic       ok;

  // Abort on the TIMEOUT-th BUS cycle so cyc is high for exactly TIMEOUT cycles.
  always_comb begin
    timeout_hit = (TIMEOUT != 0) && (cnt == 8'(TIMEOUT - 1));
    fail        = (state == BUS) && (wbm_err_i || (!wbm_ack_i && timeout_hit));
    ok          = (state == BUS) && wbm_ack_i && !wbm_err_i;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (mem_valid) state_n = BUS;
      BUS:     if (fail || ok) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_n;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      mem_ready  <= 1'b0;
      mem_rdata  <= 32'h0;
      wbm_cyc_o  <= 1'b0;
      wbm_stb_o  <= 1'b0;
      wbm_we_o   <= 1'b0;
      wbm_sel_o  <= 4'h0;
      wbm_adr_o  <= 32'h0;
      wbm_dat_o  <= 32'h0;
      bus_err_o  <= 1'b0;
      err_addr_o <= 32'h0;
      cnt        <= 8'h0;
    end else begin
      mem_ready <= 1'b0;
      // A clear is overridden below when a new failure lands on the same edge.
      if (err_clr_i) bus_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_valid) begin
            wbm_adr_o <= mem_addr;
            wbm_dat_o <= mem_wdata;
            wbm_we_o  <= |mem_wstrb;
            wbm_sel_o <= (|mem_wstrb) ? mem_wstrb : 4'hF;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            cnt       <= 8'h0;
          end
        end
        BUS: begin
          cnt <= cnt + 8'h1;
          if (fail) begin
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            mem_ready  <= 1'b1;
            bus_err_o  <= 1'b1;
            err_addr_o <= wbm_adr_o;
            if (!wbm_we_o) mem_rdata <= ERR_RDATA;
          end else if (ok) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            mem_ready <= 1'b1;
            if (!wbm_we_o) mem_rdata <= wbm_dat_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_bridge.sv
// Bench for wb_master_bridge: directed vector table, hand-written corner sequences,
// then random accesses predicted by a transaction-level model.
module tb_wb_master_bridge;

  localparam int          T       = 8;
  localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;
  localparam int K_ACK  = 0;
  localparam int K_ERR  = 1;
  localparam int K_NONE = 2;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          waits;
    int          kind;
    logic [31:0] sdata;
    logic        clr;
    int          exp_cyc;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] exp_eaddr;
  } vec_t;

  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_ack_i = 1'b0;
  logic        wbm_err_i = 1'b0;
  logic        err_clr_i = 1'b0;
  logic        bus_err_o;
  logic [31:0] err_addr_o;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mdl_rdata = '0;
  logic        mdl_err = 1'b0;
  logic [31:0] mdl_eaddr = '0;
  vec_t        tbl[9];
  vec_t        v;

  wb_master_bridge #(.TIMEOUT(T), .ERR_RDATA(ERR_VAL)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
    .err_clr_i(err_clr_i), .bus_err_o(bus_err_o), .err_addr_o(err_addr_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                              input int waits, input int kind, input logic [31:0] sdata, input logic clr,
                              input int exp_cyc, input logic [31:0] exp_rdata, input logic exp_err,
                              input logic [31:0] exp_eaddr);
    vec_t r;
    r.addr = addr; r.wdata = wdata; r.wstrb = wstrb; r.waits = waits; r.kind = kind;
    r.sdata = sdata; r.clr = clr; r.exp_cyc = exp_cyc; r.exp_rdata = exp_rdata;
    r.exp_err = exp_err; r.exp_eaddr = exp_eaddr;
    return r;
  endfunction

  // Transaction-level reference: outcome decided from response kind, wait count and TIMEOUT.
  task automatic predict(inout vec_t p);
    bit timed_out;
    bit failed;
    timed_out = (p.kind == K_NONE) || (p.waits >= T);
    failed    = timed_out || (p.kind == K_ERR);
    p.exp_cyc = timed_out ? T : p.waits + 1;
    if (p.wstrb == 4'h0) mdl_rdata = failed ? ERR_VAL : p.sdata;
    if (p.clr) mdl_err = 1'b0;
    if (failed) begin
      mdl_err   = 1'b1;
      mdl_eaddr = p.addr;
    end
    p.exp_rdata = mdl_rdata;
    p.exp_err   = mdl_err;
    p.exp_eaddr = mdl_eaddr;
  endtask

  // Driver: core side plus a responding slave; called at a negedge, returns at a negedge.
  task automatic run_access(input vec_t a, input string name);
    int          ncyc;
    bit          stable;
    logic [3:0]  esel;
    logic [31:0] exp_rd;
    esel   = (a.wstrb != 4'h0) ? a.wstrb : 4'hF;
    stable = 1'b1;
    ncyc   = 0;
    exp_q.push_back(a.exp_rdata);
    mem_valid = 1'b1; mem_addr = a.addr; mem_wdata = a.wdata; mem_wstrb = a.wstrb;
    err_clr_i = a.clr;
    @(negedge clk);
    while (wbm_cyc_o && ncyc < 300) begin
      if (!(wbm_stb_o && wbm_adr_o == a.addr && wbm_sel_o == esel &&
            wbm_we_o == (a.wstrb != 4'h0) && wbm_dat_o == a.wdata)) stable = 1'b0;
      mem_addr = $urandom; mem_wdata = $urandom; mem_wstrb = 4'($urandom_range(0, 15));
      wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_dat_i = $urandom;
      if (ncyc == a.waits && a.kind != K_NONE) begin
        wbm_ack_i = 1'b1;
        wbm_err_i = (a.kind == K_ERR);
        wbm_dat_i = a.sdata;
      end
      ncyc++;
      @(negedge clk);
    end
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
    chk({name, " cyc_cycles"}, ncyc, a.exp_cyc);
    chk({name, " bus_stable"}, {31'h0, stable}, 32'h1);
    chk({name, " ready"}, {30'h0, mem_ready, wbm_stb_o}, 32'h2);
    exp_rd = (exp_q.size() > 0) ? exp_q.pop_front() : ~mem_rdata;
    chk({name, " rdata"}, mem_rdata, exp_rd);
    chk({name, " bus_err"}, {31'h0, bus_err_o}, {31'h0, a.exp_err});
    chk({name, " err_addr"}, err_addr_o, a.exp_eaddr);
    mem_valid = 1'b0; err_clr_i = 1'b0;
    @(negedge clk);
    chk({name, " ready_one_cycle"}, {30'h0, mem_ready, wbm_cyc_o}, 32'h0);
    mdl_rdata = a.exp_rdata; mdl_err = a.exp_err; mdl_eaddr = a.exp_eaddr;
  endtask

  initial begin
    bit saw;
    tbl[0] = mk(32'h3000_0010, 32'h0, 4'h0, 0, K_ACK, 32'h1234_5678, 0, 1, 32'h1234_5678, 0, 32'h0);
    tbl[1] = mk(32'h3000_0004, 32'hA5A5_0F0F, 4'b0110, 3, K_ACK, 32'h0BAD_0BAD, 0, 4, 32'h1234_5678, 0, 32'h0);
    tbl[2] = mk(32'h3000_0100, 32'h0, 4'h0, 0, K_ERR, 32'h1111_1111, 0, 1, ERR_VAL, 1, 32'h3000_0100);
    tbl[3] = mk(32'h3000_0200, 32'h0, 4'h0, 0, K_NONE, 32'h2222_2222, 0, 8, ERR_VAL, 1, 32'h3000_0200);
    tbl[4] = mk(32'h3000_0008, 32'h0000_55AA, 4'hF, 1, K_ACK, 32'h3333_3333, 0, 2, ERR_VAL, 1, 32'h3000_0200);
    tbl[5] = mk(32'h3000_000C, 32'h0, 4'h0, 7, K_ACK, 32'hCAFE_F00D, 0, 8, 32'hCAFE_F00D, 1, 32'h3000_0200);
    tbl[6] = mk(32'h3000_0020, 32'h0, 4'h0, 8, K_ACK, 32'h4444_4444, 0, 8, ERR_VAL, 1, 32'h3000_0020);
    tbl[7] = mk(32'h3000_0030, 32'h0000_0077, 4'h1, 2, K_ERR, 32'h5555_5555, 1, 3, ERR_VAL, 1, 32'h3000_0030);
    tbl[8] = mk(32'h3000_0034, 32'h0000_1234, 4'h3, 0, K_ACK, 32'h6666_6666, 1, 1, ERR_VAL, 0, 32'h3000_0030);

    repeat (3) @(negedge clk);
    chk("reset_outputs", {28'h0, mem_ready, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 32'h0);
    chk("reset_sel_err", {27'h0, wbm_sel_o, bus_err_o}, 32'h0);
    chk("reset_data", mem_rdata | wbm_adr_o | wbm_dat_o | err_addr_o, 32'h0);
    wb_rst_i = 1'b0;

    for (int i = 0; i < 9; i++) run_access(tbl[i], $sformatf("vec%0d", i));

    // Stray ack/err while idle must be ignored.
    for (int i = 0; i < 3; i++) begin
      wbm_ack_i = 1'b1; wbm_err_i = 1'b1; wbm_dat_i = $urandom;
      @(negedge clk);
      chk($sformatf("stray%0d ctl", i), {29'h0, wbm_cyc_o, mem_ready, bus_err_o}, 32'h0);
      chk($sformatf("stray%0d data", i), mem_rdata ^ err_addr_o, ERR_VAL ^ 32'h3000_0030);
    end
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
    @(negedge clk);

    // Error then a single-cycle clear pulse.
    run_access(mk(32'h3000_0040, 32'h0, 4'h0, 1, K_ERR, 32'h7777_7777, 0, 2, ERR_VAL, 1, 32'h3000_0040), "err_read");
    err_clr_i = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;
    chk("err_clr bus_err", {31'h0, bus_err_o}, 32'h0);
    chk("err_clr err_addr", err_addr_o, 32'h3000_0040);

    // Reset during the second wait state of a read.
    run_access(mk(32'h3000_0050, 32'hFFFF_0000, 4'hF, 0, K_ERR, 32'h0, 0, 1, ERR_VAL, 1, 32'h3000_0050), "pre_rst");
    mem_valid = 1'b1; mem_addr = 32'h3000_0058; mem_wstrb = 4'h0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid in_bus", {31'h0, wbm_cyc_o}, 32'h1);
    wb_rst_i = 1'b1; mem_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid ctl", {28'h0, wbm_cyc_o, wbm_stb_o, mem_ready, bus_err_o}, 32'h0);
    chk("rst_mid data", mem_rdata | err_addr_o, 32'h0);
    wb_rst_i = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (mem_ready || wbm_cyc_o) saw = 1'b1;
    end
    chk("rst_mid no_ready", {31'h0, saw}, 32'h0);
    mdl_rdata = '0; mdl_err = 1'b0; mdl_eaddr = '0;
    run_access(mk(32'h3000_0060, 32'h0, 4'h0, 2, K_ACK, 32'h600D_F00D, 0, 3, 32'h600D_F00D, 0, 32'h0), "post_rst");

    // Random accesses against the model.
    for (int i = 0; i < 40; i++) begin
      int r;
      v.addr  = $urandom;
      v.wdata = $urandom;
      v.wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      v.waits = $urandom_range(0, 10);
      r = $urandom_range(0, 5);
      v.kind  = (r < 3) ? K_ACK : (r < 5) ? K_ERR : K_NONE;
      v.sdata = $urandom;
      v.clr   = ($urandom_range(0, 7) == 0);
      predict(v);
      run_access(v, $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_master_bridge.md
Name: wb_master_bridge

Overview:
Wishbone classic initiator that turns the picorv32 native memory interface (valid/ready) into single Wishbone read/write cycles. It is the master-side counterpart to the user-area Wishbone responder. It drives an internal Wishbone bus toward user peripherals and memories. Bus errors and no-response timeouts are reported to the core as completed accesses and are logged in a sticky status.

Parameters:
TIMEOUT, 255, number of BUS-state cycles without ack/err before abort; 0 disables the timeout; range 0..255
ERR_RDATA, 32'hDEAD_BEEF, read data returned to the core on an error or timeout

Ports:
wb_clk_i  in  1  single clock
wb_rst_i  in  1  synchronous reset, active-high
mem_valid  in  1  core request valid
mem_addr  in  32  byte address
mem_wdata  in  32  write data
mem_wstrb  in  4  byte strobes; 0 = read, nonzero = write
mem_ready  out  1  one-cycle completion pulse
mem_rdata  out  32  read data, valid while mem_ready=1
wbm_cyc_o  out  1  Wishbone cycle
wbm_stb_o  out  1  Wishbone strobe
wbm_we_o  out  1  write enable
wbm_sel_o  out  4  byte selects
wbm_adr_o  out  32  address
wbm_dat_o  out  32  write data
wbm_dat_i  in  32  read data
wbm_ack_i  in  1  slave acknowledge
wbm_err_i  in  1  slave error
err_clr_i  in  1  clears the sticky error
bus_err_o  out  1  sticky: an error or timeout has occurred
err_addr_o  out  32  address of the most recent failed access

Behaviour:
- Reset values: all outputs 0 (mem_ready, mem_rdata, wbm_*_o, bus_err_o, err_addr_o). FSM = IDLE. Timeout counter = 0.
- All outputs are registered. No combinational path from any input to any output.
- State IDLE:
  - If mem_valid=1 at a clock edge: latch adr = mem_addr, dat_o = mem_wdata, we = |mem_wstrb.
  - sel = mem_wstrb on a write, 4'hF on a read.
  - Assert cyc=stb=1 and go to BUS.
- State BUS:
  - cyc, stb, adr, sel, we and dat_o are held stable. The counter increments once per cycle.
  - On err_i=1 (err takes precedence over ack when both are high), or when the counter reaches TIMEOUT with no ack (only if TIMEOUT≠0):
    - drop cyc/stb on the same edge;
    - drive mem_rdata = ERR_RDATA on a read, leave it unchanged on a write;
    - set bus_err_o=1 and err_addr_o = adr;
    - go to DONE.
  - On ack_i=1 with err_i=0:
    - drop cyc/stb on the same edge;
    - capture mem_rdata = wbm_dat_i on a read, leave it unchanged on a write;
    - go to DONE.
- State DONE:
  - mem_ready=1 for exactly one cycle, then return to IDLE. cyc/stb are 0.
  - mem_valid is ignored in this cycle, because the core drops it on the edge where it samples ready.
  - A new request is accepted from IDLE on the following edge.
- Latency with a zero-wait slave: mem_valid sampled at edge N → cyc/stb high in cycle N+1 → ack sampled at edge N+1 → mem_ready high in cycle N+2. Each slave wait state adds one cycle.
- Timeout abort point: cyc/stb are high for exactly TIMEOUT cycles before dropping.
- stb is never asserted outside cyc. Only one outstanding access at a time; no pipelining and no bursts.
- bus_err_o is sticky until err_clr_i=1. If err_clr_i=1 on the same edge that a new error is recorded, the set wins: bus_err_o stays 1 and err_addr_o is updated.
- An ack/err arriving while in IDLE or DONE is ignored and does not change state or status.
- A change on mem_addr/mem_wdata/mem_wstrb during BUS has no effect, because the values were latched in IDLE.
- Reset asserted mid-cycle: on the next edge cyc/stb drop to 0, the FSM goes to IDLE, mem_ready=0 and the sticky status clears. The aborted access is not completed.

Test Plan:
- Zero-wait read: mem_valid, addr 0x3000_0010, wstrb 0; slave acks in the first cyc cycle with dat 0x1234_5678 → cyc/stb high 1 cycle, sel 4'hF, we 0; mem_ready pulses 2 cycles after valid with rdata 0x1234_5678.
- Write with 3 wait states: addr 0x3000_0004, wdata 0xA5A5_0F0F, wstrb 4'b0110 → we 1, sel 4'b0110, dat_o stable for 4 cycles; mem_ready 1 cycle after ack; mem_rdata unchanged.
- Error: read of 0x3000_0100, slave asserts err with ack in the same cycle → rdata 0xDEAD_BEEF, bus_err_o=1, err_addr_o=0x3000_0100. Then pulse err_clr_i → bus_err_o=0.
- Timeout: TIMEOUT=8, slave never responds → cyc high exactly 8 cycles, mem_ready pulses, rdata 0xDEAD_BEEF, bus_err_o=1.
- Back-to-back: the core re-asserts valid in the cycle after ready, with a write then a read → a second cyc starts 1 cycle after DONE; both accesses complete with correct sel/we; cyc drops between the two accesses.
- Reset mid-cycle: assert wb_rst_i during the 2nd wait state of a read → cyc/stb/mem_ready are 0 on the next edge, no ready pulse occurs, and a fresh read after reset completes normally.
